// File: rtl/rsa_pkg.sv
// Shared constants and types for the RSA block sequencer front end.
package rsa_pkg;

  localparam int WORD_W          = 32;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_WORD  = 4;
  localparam int TIMEOUT_DEFAULT = 4096;

  typedef enum logic [2:0] {
    FILL,
    CHECK,
    LAUNCH,
    WAIT,
    EMIT
  } state_t;

endpackage

// File: rtl/rsa_block_sequencer_if.sv
// Byte input stream, core launch/return bus and cipher output stream.
interface rsa_block_sequencer_if;
  import rsa_pkg::*;

  logic [BYTE_W-1:0] in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [WORD_W-1:0] n;
  logic              core_start;
  logic [WORD_W-1:0] core_msg;
  logic              core_done;
  logic [WORD_W-1:0] core_cipher;
  logic [WORD_W-1:0] out_word;
  logic              out_valid;
  logic              out_ready;
  logic              out_err;
  logic              out_last;

  // Sequencer side.
  modport master (
    input  in_byte, in_valid, in_last, n, core_done, core_cipher, out_ready,
    output in_ready, core_start, core_msg, out_word, out_valid, out_err, out_last
  );

  // Environment side: byte source, exponentiation core and output sink.
  modport slave (
    output in_byte, in_valid, in_last, n, core_done, core_cipher, out_ready,
    input  in_ready, core_start, core_msg, out_word, out_valid, out_err, out_last
  );

endinterface

// File: rtl/rsa_byte_packer.sv
// Packs bytes big-endian into a word; a short word is left-justified with
// zero padding in its low bytes.
module rsa_byte_packer
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              last_in,
  input  logic              clear,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              word_end,
  output logic              last_flag
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD + 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

  logic [WORD_W-1:0] shift;
  logic [CNT_W-1:0]  count;

  // Move the k collected bytes from the low end up to the top of the word.
  function automatic logic [WORD_W-1:0] justify(input logic [WORD_W-1:0] s,
                                                input logic [CNT_W-1:0] c);
    case (c)
      CNT_W'(1): justify = s << 24;
      CNT_W'(2): justify = s << 16;
      CNT_W'(3): justify = s << 8;
      default:   justify = s;
    endcase
  endfunction

  // Shift register, byte count and last-byte capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift     <= '0;
      count     <= '0;
      last_flag <= 1'b0;
    end else if (clear) begin
      shift     <= '0;
      count     <= '0;
      last_flag <= 1'b0;
    end else if (accept) begin
      shift     <= {shift[WORD_W-BYTE_W-1:0], byte_in};
      count     <= count + CNT_W'(1);
      last_flag <= last_in;
    end
  end

  assign word       = justify(shift, count);
  assign word_valid = (count == FULL) || last_flag;
  // The byte being accepted now completes the word.
  assign word_end   = accept && (last_in || (count == LAST_IDX));

endmodule

// File: rtl/rsa_block_sequencer.sv
// Collects a message word, range-checks it against n, runs the core with
// a timeout and presents the cipher (or error) on the output stream.
module rsa_block_sequencer
  import rsa_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  rsa_block_sequencer_if.master bus
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  state_t            next_state;
  logic [TMR_W-1:0]  timer;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              word_end;
  logic              last_flag;
  logic              accept;
  logic              pack_clear;
  logic              range_err;
  logic              timeout;

  assign accept    = bus.in_valid && bus.in_ready;
  assign range_err = (bus.n < 32'd2) || (word >= bus.n);
  assign timeout   = (timer == TMR_LAST);

  rsa_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .accept     (accept),
    .byte_in    (bus.in_byte),
    .last_in    (bus.in_last),
    .clear      (pack_clear),
    .word       (word),
    .word_valid (word_valid),
    .word_end   (word_end),
    .last_flag  (last_flag)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= next_state;
  end

  // Next-state decode; core_done beats a same-cycle timeout.
  always_comb begin
    next_state = state;
    case (state)
      FILL:    if (word_end) next_state = CHECK;
      CHECK:   next_state = (word_valid && !range_err) ? LAUNCH : EMIT;
      LAUNCH:  next_state = WAIT;
      WAIT:    if (bus.core_done || timeout) next_state = EMIT;
      EMIT:    if (bus.out_ready) next_state = FILL;
      default: next_state = FILL;
    endcase
  end

  // Unregistered controls decoded from the state register.
  always_comb begin
    bus.in_ready = (state == FILL);
    pack_clear   = (state == EMIT) && bus.out_ready;
  end

  // Registered core launch, timer and output word/flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.core_start <= 1'b0;
      bus.core_msg   <= '0;
      bus.out_word   <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_err    <= 1'b0;
      bus.out_last   <= 1'b0;
      timer          <= '0;
    end else begin
      bus.core_start <= (state == CHECK) && (next_state == LAUNCH);
      case (state)
        CHECK: begin
          if (next_state == LAUNCH) begin
            bus.core_msg <= word;
          end else begin
            bus.out_word  <= word;
            bus.out_err   <= 1'b1;
            bus.out_valid <= 1'b1;
            bus.out_last  <= last_flag;
          end
        end
        LAUNCH: timer <= '0;
        WAIT: begin
          if (bus.core_done) begin
            bus.out_word  <= bus.core_cipher;
            bus.out_err   <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_last  <= last_flag;
          end else if (timeout) begin
            bus.out_word  <= '0;
            bus.out_err   <= 1'b1;
            bus.out_valid <= 1'b1;
            bus.out_last  <= last_flag;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        EMIT: if (bus.out_ready) bus.out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_block_sequencer.sv
// Directed bench for rsa_block_sequencer with a behavioural core and an
// expected-output queue.
module tb_rsa_block_sequencer;
  import rsa_pkg::*;

  localparam int TMO = 16;

  typedef struct {
    logic [31:0] word;
    logic        err;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rsa_block_sequencer_if bus();

  rsa_block_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Core model state
  int          core_lat = 10;
  logic [31:0] core_resp = 32'd0;
  logic        core_en = 1'b1;
  logic        force_done = 1'b0;
  int          starts = 0;
  int          pend_cnt = 0;
  logic        pend = 1'b0;

  // Behavioural exponentiation core: answers core_lat cycles after start.
  always @(negedge clk) begin
    bus.core_done = 1'b0;
    if (!reset) pend = 1'b0;
    if (force_done) begin
      bus.core_done = 1'b1;
      force_done = 1'b0;
    end
    if (pend) begin
      if (pend_cnt == 0) begin
        bus.core_done   = 1'b1;
        bus.core_cipher = core_resp;
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (bus.core_start) begin
      starts++;
      if (core_en) begin
        pend = 1'b1;
        pend_cnt = core_lat - 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input logic l);
    int g = 0;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    bus.in_last  = l;
    while (!bus.in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("in_ready_timeout", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b0);
  endtask

  task automatic push_exp(input logic [31:0] w, input logic e, input logic l);
    exp_t x;
    x.word = w;
    x.err  = e;
    x.last = l;
    sb.push_back(x);
  endtask

  // Wait for out_valid, compare against the queue head, optionally hold
  // back-pressure, then complete the handshake.
  task automatic expect_out(input int hold);
    int g = 0;
    exp_t e;
    logic [31:0] w0;
    logic e0, l0;
    logic stable = 1'b1;
    while (!bus.out_valid && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("out_valid_seen", bus.out_valid, 1);
    check("sb_depth", sb.size(), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("out_word", bus.out_word, e.word);
    check("out_err", bus.out_err, e.err);
    check("out_last", bus.out_last, e.last);
    if (hold > 0) begin
      w0 = bus.out_word;
      e0 = bus.out_err;
      l0 = bus.out_last;
      repeat (hold) begin
        @(negedge clk);
        if (bus.out_valid !== 1'b1 || bus.out_word !== w0 || bus.out_err !== e0 ||
            bus.out_last !== l0 || bus.in_ready !== 1'b0) stable = 1'b0;
      end
      check("hold_stable", stable, 1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_drop", bus.out_valid, 0);
    check("in_ready_after_hs", bus.in_ready, 1);
  endtask

  initial begin
    int s0;
    int cnt;
    logic extra;
    bus.in_byte   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.n         = 32'd3233;
    bus.out_ready = 1'b0;
    bus.core_done = 1'b0;
    bus.core_cipher = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_core_start", bus.core_start, 0);
    check("rst_core_msg", bus.core_msg, 0);
    check("rst_out_word", bus.out_word, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_out_last", bus.out_last, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);

    // Normal encryption with launch timing
    s0 = starts;
    core_resp = 32'd2790;
    bus.n = 32'd3233;
    push_exp(32'd2790, 1'b0, 1'b0);
    send_word(32'h0000_0041);
    check("t1_start_check_cycle", bus.core_start, 0);
    @(negedge clk);
    check("t1_start_launch_cycle", bus.core_start, 1);
    check("t1_core_msg", bus.core_msg, 32'h41);
    @(negedge clk);
    check("t1_start_one_cycle", bus.core_start, 0);
    expect_out(0);
    check("t1_starts", starts - s0, 1);

    // Partial word with in_last, left-justified
    s0 = starts;
    core_resp = 32'h1234_5678;
    bus.n = 32'hFFFF_FFFF;
    push_exp(32'h1234_5678, 1'b0, 1'b1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b1);
    expect_out(0);
    check("t2_core_msg", bus.core_msg, 32'h0102_0000);
    check("t2_starts", starts - s0, 1);

    // Range error: 0x1000 >= 3233
    s0 = starts;
    bus.n = 32'd3233;
    push_exp(32'h0000_1000, 1'b1, 1'b0);
    send_word(32'h0000_1000);
    check("t3_valid_in_check", bus.out_valid, 0);
    @(negedge clk);
    check("t3_valid_after_check", bus.out_valid, 1);
    expect_out(0);
    check("t3_no_start", starts - s0, 0);

    // Timeout with a silent core, then a late done
    s0 = starts;
    core_en = 1'b0;
    push_exp(32'd0, 1'b1, 1'b0);
    send_word(32'h0000_0005);
    @(negedge clk);
    check("t4_start", bus.core_start, 1);
    cnt = 0;
    while (!bus.out_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("t4_timeout_latency", cnt, TMO + 1);
    expect_out(0);
    force_done = 1'b1;
    extra = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) extra = 1'b1;
    end
    check("t4_late_done_ignored", extra, 0);
    check("t4_starts", starts - s0, 1);
    core_en = 1'b1;

    // Back-pressure on the output
    core_resp = 32'd77;
    push_exp(32'd77, 1'b0, 1'b0);
    send_word(32'h0000_0007);
    expect_out(20);

    // Reset while waiting on the core
    core_resp = 32'd999;
    send_word(32'h0000_0009);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_rst_core_start", bus.core_start, 0);
    check("t6_rst_core_msg", bus.core_msg, 0);
    check("t6_rst_out_word", bus.out_word, 0);
    check("t6_rst_out_valid", bus.out_valid, 0);
    check("t6_rst_out_err", bus.out_err, 0);
    check("t6_rst_out_last", bus.out_last, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_in_ready", bus.in_ready, 1);
    check("t6_no_stale_output", bus.out_valid, 0);
    s0 = starts;
    core_resp = 32'd2790;
    push_exp(32'd2790, 1'b0, 1'b0);
    send_word(32'h0000_0041);
    expect_out(0);
    check("t6_core_msg", bus.core_msg, 32'h41);
    check("t6_starts", starts - s0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rsa_block_sequencer.md
# rsa_block_sequencer

Front-end stage for the RSA modular-exponentiation core: accepts plaintext as a byte stream and packs each group of 4 bytes big-endian into a 32-bit message word. It range-checks the word against the modulus, launches the core with a one-cycle start pulse, and waits for the core's done (with a timeout). It then returns the 32-bit cipher word on a valid/ready output stream, together with error and last flags.

## Interface
- TIMEOUT_CYCLES, 4096: maximum cycles spent in WAIT before the block is aborted with an error.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_byte  in  8  plaintext byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  block accepts a byte this cycle.
- in_last  in  1  accompanies the final byte of a message; it flushes a partial word.
- n  in  32  modulus; must be stable from the first byte of a word until out_valid.
- core_start  out  1  one-cycle launch pulse to the exponentiation core.
- core_msg  out  32  message word to the core; held from LAUNCH through WAIT.
- core_done  in  1  core completion; sampled only in WAIT.
- core_cipher  in  32  core result; valid when core_done=1.
- out_word  out  32  cipher word, or the offending message word on error.
- out_valid  out  1  out_word, out_err and out_last are valid.
- out_ready  in  1  downstream accepts the output.
- out_err  out  1  1 = range error or timeout; out_word then carries no cipher.
- out_last  out  1  this word closes the message (in_last was seen).

## Operation
- States:
  - FILL: in_ready=1; a byte is accepted on in_valid&&in_ready. The word shifts left by 8 and the new byte enters bits [7:0]. The byte count increments and the in_last flag is captured.
    - Go to CHECK after the 4th byte, or on any accepted byte with in_last=1.
    - Partial word (k<4 bytes): remaining low bytes are zero-padded, so the word is left-justified (byte 0 lands in [31:24]).
  - CHECK (1 cycle):
    - If n<2 or word>=n: go to EMIT with out_err=1 and out_word=word.
    - Otherwise load core_msg=word and go to LAUNCH.
  - LAUNCH (1 cycle): core_start=1; clear the timer; go to WAIT.
  - WAIT: the timer increments each cycle.
    - On core_done=1: capture core_cipher into out_word, set out_err=0, go to EMIT.
    - If core_done is not seen and the timer reaches TIMEOUT_CYCLES-1: set out_word=0, out_err=1, go to EMIT.
    - If core_done and timeout occur in the same cycle, core_done wins.
  - EMIT: out_valid=1 and all outputs are held until out_ready=1. On that handshake, clear the byte count, last flag and word register, then go to FILL.
- in_ready=0 in every state except FILL; bytes are never dropped, only back-pressured.
- core_done outside WAIT is ignored. A late done arriving after a timeout must not produce a second output.
- Range compare is unsigned 32-bit. The timer width is clog2(TIMEOUT_CYCLES).
- Reset mid-operation: return to FILL immediately, discard any partial word or in-flight result, and deassert core_start and out_valid.

## Timing
- Reset values:
  - State FILL, byte count 0, timer 0.
  - core_start=0, core_msg=0, out_word=0, out_valid=0, out_err=0, out_last=0.
  - in_ready=1 once reset is released.
- All outputs are registered except in_ready, which is decoded from the state register.
- Last byte accepted at edge t: CHECK during t+1, core_start high during t+2 for exactly one cycle.
- Range error: out_valid rises in the cycle after CHECK (t+2).
- core_done sampled at edge d: out_valid high from d+1.
- out_valid && out_ready at edge h: in_ready high from h+1. Minimum period per word is 4 byte cycles + CHECK + LAUNCH + core latency + 1.
- Timeout: out_valid rises exactly TIMEOUT_CYCLES+1 cycles after core_start.

## Structure
- Shared package rsa_pkg holds:
  - WORD_W=32 and BYTES_PER_WORD=4.
  - The state enum (FILL, CHECK, LAUNCH, WAIT, EMIT).
  - The default timeout constant.
- One natural sub-module is rsa_byte_packer, which owns the byte shift register, byte count, in_last capture and zero-padding, and exposes word, word_valid and a clear input.
- The FSM, range check, timer and output register stay in rsa_block_sequencer.

## Test plan
- Four bytes 0x00,0x00,0x00,0x41 with n=3233; core model returns 2790 after 10 cycles → core_msg=0x41, one core_start pulse, out_word=2790, out_err=0, out_last=0.
- Bytes 0x01,0x02 with in_last on 0x02 and n=0xFFFFFFFF → core_msg=0x01020000; output has out_last=1.
- Word 0x00001000 with n=3233 (4096>=3233) → no core_start; out_word=0x00001000, out_err=1.
- TIMEOUT_CYCLES=16 and the core never asserts done → out_valid exactly 17 cycles after core_start with out_word=0, out_err=1. A done asserted afterwards produces no extra output.
- Hold out_ready=0 for 20 cycles after out_valid → outputs stable and in_ready=0 throughout; the next word is accepted the cycle after the handshake.
- Assert reset in WAIT, then release → all outputs at reset values, in_ready=1, and a fresh 4-byte word launches normally.
